// File: rtl/ceres_param.sv
// Shared types and constants for the fetch aligner.
// Halfword queue entry (data + access-fault flag) and queue depth.
package ceres_param;

   localparam int ALIGN_DEPTH_HW = 4;

   typedef struct packed {
      logic [15:0] data;
      logic        err;
   } hw_entry_t;

   function automatic logic is_rvc(input logic [15:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/riscv_fetch_aligner.sv
// Fetch aligner: splits 32-bit fetch words into 16/32-bit instructions.
// Ports: clk_i/rst_i, flush_i/flush_pc_i, fetch_* in, instr_* out.
module riscv_fetch_aligner
   import ceres_param::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_data_i,
   input  logic        fetch_err_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_err_o
);

   hw_entry_t   q_q [ALIGN_DEPTH_HW];
   hw_entry_t   q_d [ALIGN_DEPTH_HW];
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d;
   logic        skip_q, skip_d;

   logic        short_c;
   logic        enq, deq;
   logic [2:0]  pop;
   logic [2:0]  mid;
   hw_entry_t   lo_e, hi_e;

   // An errored head is emitted alone so the fault is reported
   // without waiting for a second halfword that may never come.
   assign short_c = is_rvc(q_q[0].data) | q_q[0].err;

   assign instr_valid_o = (cnt_q >= 3'd1 && short_c) ||
                          (cnt_q >= 3'd2);
   assign instr_o     = short_c ? {16'h0000, q_q[0].data}
                                : {q_q[1].data, q_q[0].data};
   assign instr_err_o = short_c ? q_q[0].err
                                : (q_q[0].err | q_q[1].err);
   assign instr_pc_o  = pc_q;

   assign fetch_ready_o = (cnt_q <= 3'd2) && !flush_i;

   assign enq = fetch_valid_i & fetch_ready_o;
   assign deq = instr_valid_o & instr_ready_i;
   assign pop = deq ? (short_c ? 3'd1 : 3'd2) : 3'd0;
   assign mid = cnt_q - pop;

   assign lo_e = '{data: fetch_data_i[15:0],  err: fetch_err_i};
   assign hi_e = '{data: fetch_data_i[31:16], err: fetch_err_i};

   always_comb begin
      q_d    = q_q;
      cnt_d  = cnt_q;
      pc_d   = pc_q;
      skip_d = skip_q;

      unique case (pop)
         3'd1: q_d = '{q_q[1], q_q[2], q_q[3], hw_entry_t'('0)};
         3'd2: q_d = '{q_q[2], q_q[3], hw_entry_t'('0),
                       hw_entry_t'('0)};
         default: q_d = q_q;
      endcase

      // Accept only happens with count<=2, so mid+1 stays in range.
      for (int i = 0; i < ALIGN_DEPTH_HW; i++) begin
         if (enq && 3'(i) == mid)
            q_d[i] = skip_q ? hi_e : lo_e;
         if (enq && !skip_q && 3'(i) == mid + 3'd1)
            q_d[i] = hi_e;
      end

      cnt_d = mid + (enq ? (skip_q ? 3'd1 : 3'd2) : 3'd0);
      pc_d  = pc_q + (deq ? (short_c ? 32'd2 : 32'd4) : 32'd0);
      if (enq)
         skip_d = 1'b0;

      if (flush_i) begin
         for (int i = 0; i < ALIGN_DEPTH_HW; i++)
            q_d[i] = '0;
         cnt_d  = 3'd0;
         pc_d   = {flush_pc_i[31:1], 1'b0};
         skip_d = flush_pc_i[1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ALIGN_DEPTH_HW; i++)
            q_q[i] <= '0;
         cnt_q  <= 3'd0;
         pc_q   <= RESET_PC;
         skip_q <= RESET_PC[1];
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         pc_q   <= pc_d;
         skip_q <= skip_d;
      end
   end

endmodule

// File: tb/tb_riscv_fetch_aligner.sv
// Directed bench for riscv_fetch_aligner.
// Drives fetch words, checks emitted instructions and PCs.
module tb_riscv_fetch_aligner;

   logic        clk = 1'b0;
   logic        rst, flush, fvalid, fready, ferr;
   logic [31:0] flush_pc, fdata;
   logic        ivalid, iready, ierr;
   logic [31:0] instr, ipc;

   int n_chk = 0;
   int n_bad = 0;

   riscv_fetch_aligner #(.RESET_PC(32'h8000_0000)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .flush_pc_i   (flush_pc),
      .fetch_valid_i(fvalid),
      .fetch_ready_o(fready),
      .fetch_data_i (fdata),
      .fetch_err_i  (ferr),
      .instr_valid_o(ivalid),
      .instr_ready_i(iready),
      .instr_o      (instr),
      .instr_pc_o   (ipc),
      .instr_err_o  (ierr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [31:0] w, input logic e);
      fvalid = 1'b1;
      fdata  = w;
      ferr   = e;
      step();
      fvalid = 1'b0;
      ferr   = 1'b0;
   endtask

   logic [31:0] words [4];
   logic [15:0] exp_hw [6];
   int idx, k;
   logic acc, em;

   initial begin
      rst = 1'b1; flush = 1'b0; flush_pc = '0;
      fvalid = 1'b0; fdata = '0; ferr = 1'b0; iready = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(ivalid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", ipc, 32'h8000_0000);
      chk("rst_err", 32'(ierr), 32'd0);
      chk("rst_ready", 32'(fready), 32'd1);

      // two compressed then one 32-bit
      feed(32'h0001_4501, 1'b0);
      chk("c0_valid", 32'(ivalid), 32'd1);
      chk("c0_instr", instr, 32'h0000_4501);
      chk("c0_pc", ipc, 32'h8000_0000);
      fvalid = 1'b1; fdata = 32'h0000_0013; iready = 1'b1;
      chk("c1_fready", 32'(fready), 32'd1);
      step();
      fvalid = 1'b0;
      chk("c1_instr", instr, 32'h0000_0001);
      chk("c1_pc", ipc, 32'h8000_0002);
      step();
      chk("w2_instr", instr, 32'h0000_0013);
      chk("w2_pc", ipc, 32'h8000_0004);
      step();
      chk("w2_empty", 32'(ivalid), 32'd0);

      // straddling 32-bit instruction
      iready = 1'b0;
      feed(32'h0513_4505, 1'b0);
      chk("st_c_instr", instr, 32'h0000_4505);
      chk("st_c_pc", ipc, 32'h8000_0008);
      iready = 1'b1;
      step();
      chk("st_wait0", 32'(ivalid), 32'd0);
      step();
      chk("st_wait1", 32'(ivalid), 32'd0);
      chk("st_wait_pc", ipc, 32'h8000_000A);
      iready = 1'b0;
      feed(32'h1234_0000, 1'b0);
      chk("st_valid", 32'(ivalid), 32'd1);
      chk("st_instr", instr, 32'h0000_0513);
      chk("st_pc", ipc, 32'h8000_000A);
      iready = 1'b1;
      step();
      chk("st_tail", instr, 32'h0000_1234);
      chk("st_tail_pc", ipc, 32'h8000_000E);
      step();
      chk("st_empty", 32'(ivalid), 32'd0);
      iready = 1'b0;

      // flush with a live handshake and input word
      feed(32'h0001_0001, 1'b0);
      flush = 1'b1; flush_pc = 32'h8000_0103;
      fvalid = 1'b1; fdata = 32'hDEAD_BEEF; iready = 1'b1;
      #1;
      chk("fl_fready", 32'(fready), 32'd0);
      chk("fl_ivalid", 32'(ivalid), 32'd1);
      step();
      flush = 1'b0; fvalid = 1'b0; iready = 1'b0;
      #1;
      chk("fl_empty", 32'(ivalid), 32'd0);
      chk("fl_pc", ipc, 32'h8000_0102);
      chk("fl_ready", 32'(fready), 32'd1);
      feed(32'h4785_AAAA, 1'b0);
      chk("fl_valid", 32'(ivalid), 32'd1);
      chk("fl_instr", instr, 32'h0000_4785);
      chk("fl_ipc", ipc, 32'h8000_0102);
      iready = 1'b1;
      step();
      iready = 1'b0;
      chk("fl_done", 32'(ivalid), 32'd0);
      chk("fl_done_pc", ipc, 32'h8000_0104);

      // backpressure with streaming input
      words[0] = 32'h0009_0005;
      words[1] = 32'h0011_000D;
      words[2] = 32'h0019_0015;
      words[3] = 32'h0;
      exp_hw = '{16'h0005, 16'h0009, 16'h000D,
                 16'h0011, 16'h0015, 16'h0019};
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         fvalid = (idx < 3);
         fdata  = words[idx];
         #1;
         acc = fvalid && fready;
         step();
         if (acc) idx++;
         chk("bp_hold", instr, 32'h0000_0005);
      end
      chk("bp_fready", 32'(fready), 32'd0);
      chk("bp_accepted", 32'(idx), 32'd2);
      chk("bp_valid", 32'(ivalid), 32'd1);
      iready = 1'b1;
      k = 0;
      for (int c = 0; c < 30 && k < 6; c++) begin
         fvalid = (idx < 3);
         fdata  = words[idx];
         #1;
         acc = fvalid && fready;
         em  = ivalid && iready;
         if (em) begin
            chk("bp_instr", instr, {16'h0, exp_hw[k]});
            chk("bp_pc", ipc, 32'h8000_0104 + 32'(2 * k));
            k++;
         end
         step();
         if (acc) idx++;
      end
      fvalid = 1'b0;
      chk("bp_count", 32'(k), 32'd6);
      chk("bp_drained", 32'(ivalid), 32'd0);
      iready = 1'b0;

      // access fault on a 32-bit-looking low half
      feed(32'h0001_FFFF, 1'b1);
      chk("er_valid", 32'(ivalid), 32'd1);
      chk("er_instr", instr, 32'h0000_FFFF);
      chk("er_err", 32'(ierr), 32'd1);
      chk("er_pc", ipc, 32'h8000_0110);
      iready = 1'b1;
      step();
      chk("er_next_pc", ipc, 32'h8000_0112);
      chk("er_next_err", 32'(ierr), 32'd1);
      step();
      chk("er_empty", 32'(ivalid), 32'd0);
      iready = 1'b0;

      // reset overrides flush with count=3
      feed(32'h0001_0001, 1'b0);
      iready = 1'b1;
      feed(32'h0001_0001, 1'b0);
      iready = 1'b0;
      chk("r3_fready", 32'(fready), 32'd0);
      rst = 1'b1; flush = 1'b1; flush_pc = 32'h1234_5678;
      fvalid = 1'b1; fdata = 32'h0001_0001; iready = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0; fvalid = 1'b0; iready = 1'b0;
      #1;
      chk("r3_valid", 32'(ivalid), 32'd0);
      chk("r3_pc", ipc, 32'h8000_0000);
      chk("r3_instr", instr, 32'h0);
      chk("r3_ready", 32'(fready), 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
